// File: rtl/four_digit_display_decoder.sv
// four_digit_display_decoder
// Reads back four active-low 7-segment digit patterns (display3 = most
// significant) and rebuilds the 11-bit binary value they show.
//
// - One digit is folded into the accumulator per clock, so a conversion takes
//   four CONV cycles.
// - Blanks are accepted only as leading digits.
// - Results above 2047 saturate to 2047 and raise overflow.
module four_digit_display_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  display3,
    input  logic [6:0]  display2,
    input  logic [6:0]  display1,
    input  logic [6:0]  display0,
    output logic [10:0] value,
    output logic        done,
    output logic        busy,
    output logic        invalid,
    output logic        overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // Returns {legal, blank, digit[3:0]} for one active-low pattern (g..a).
    function automatic logic [5:0] decode_digit(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'b1000000: res = {1'b1, 1'b0, 4'd0};
            7'b1111001: res = {1'b1, 1'b0, 4'd1};
            7'b0100100: res = {1'b1, 1'b0, 4'd2};
            7'b0110000: res = {1'b1, 1'b0, 4'd3};
            7'b0011001: res = {1'b1, 1'b0, 4'd4};
            7'b0010010: res = {1'b1, 1'b0, 4'd5};
            7'b0000010: res = {1'b1, 1'b0, 4'd6};
            7'b1111000: res = {1'b1, 1'b0, 4'd7};
            7'b0000000: res = {1'b1, 1'b0, 4'd8};
            7'b0010000: res = {1'b1, 1'b0, 4'd9};
            7'b1111111: res = {1'b1, 1'b1, 4'd0};
            default:    res = {1'b0, 1'b0, 4'd0};
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] snap_q, snap_d;
    logic [13:0] acc_q, acc_d;
    logic [1:0]  idx_q, idx_d;
    logic        inv_flag_q, inv_flag_d;
    logic        seen_q, seen_d;
    logic [10:0] value_q, value_d;
    logic        done_q, done_d;
    logic        invalid_q, invalid_d;
    logic        overflow_q, overflow_d;

    logic [6:0]  pat_s;
    logic [5:0]  dec_s;
    logic [3:0]  digit_s;
    logic        nxt_inv_s;
    logic        nxt_seen_s;
    logic [13:0] acc_s;

    // Next-state logic: snapshot on start, then fold one digit per CONV cycle.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        inv_flag_d = inv_flag_q;
        seen_d     = seen_q;
        value_d    = value_q;
        invalid_d  = invalid_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        nxt_inv_s  = inv_flag_q;
        nxt_seen_s = seen_q;
        digit_s    = 4'd0;

        // Select the digit pattern for the current index.
        case (idx_q)
            2'd3:    pat_s = snap_q[27:21];
            2'd2:    pat_s = snap_q[20:14];
            2'd1:    pat_s = snap_q[13:7];
            default: pat_s = snap_q[6:0];
        endcase
        dec_s = decode_digit(pat_s);

        // Classify the digit.
        // Any non-blank pattern, legal or not, ends the run of leading blanks.
        if (!dec_s[5]) begin
            nxt_inv_s  = 1'b1;
            nxt_seen_s = 1'b1;
        end else if (dec_s[4]) begin
            if (seen_q) begin
                nxt_inv_s = 1'b1;
            end else begin
                nxt_inv_s = inv_flag_q;
            end
        end else begin
            nxt_seen_s = 1'b1;
            digit_s    = dec_s[3:0];
        end

        // acc*10 + digit, using shifts; 9999 fits in 14 bits.
        acc_s = (acc_q << 3) + (acc_q << 1) + {10'd0, digit_s};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d     = {display3, display2, display1, display0};
                    acc_d      = 14'd0;
                    inv_flag_d = 1'b0;
                    seen_d     = 1'b0;
                    idx_d      = 2'd3;
                    state_d    = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                acc_d      = acc_s;
                inv_flag_d = nxt_inv_s;
                seen_d     = nxt_seen_s;
                idx_d      = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    state_d    = ST_IDLE;
                    value_d    = (acc_s > 14'd2047) ? 11'd2047 : acc_s[10:0];
                    overflow_d = (acc_s > 14'd2047);
                    invalid_d  = nxt_inv_s;
                    done_d     = 1'b1;
                end else begin
                    state_d = ST_CONV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= 28'd0;
            acc_q      <= 14'd0;
            idx_q      <= 2'd3;
            inv_flag_q <= 1'b0;
            seen_q     <= 1'b0;
            value_q    <= 11'd0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            inv_flag_q <= inv_flag_d;
            seen_q     <= seen_d;
            value_q    <= value_d;
            done_q     <= done_d;
            invalid_q  <= invalid_d;
            overflow_q <= overflow_d;
        end
    end

    assign value    = value_q;
    assign done     = done_q;
    assign invalid  = invalid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == ST_CONV);

endmodule

// File: tb/tb_four_digit_display_decoder.sv
// Self-checking bench for four_digit_display_decoder.
// Expected results are queued when a conversion is started and compared
// against the outputs whenever done is seen.
module tb_four_digit_display_decoder;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b0101010;

    typedef struct packed {
        logic [10:0] value;
        logic        invalid;
        logic        overflow;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  display3, display2, display1, display0;
    logic [10:0] value;
    logic        done, busy, invalid, overflow;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    four_digit_display_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .display3 (display3),
        .display2 (display2),
        .display1 (display1),
        .display0 (display0),
        .value    (value),
        .done     (done),
        .busy     (busy),
        .invalid  (invalid),
        .overflow (overflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("value", {21'd0, value}, {21'd0, e.value});
                check_eq("invalid", {31'd0, invalid}, {31'd0, e.invalid});
                check_eq("overflow", {31'd0, overflow}, {31'd0, e.overflow});
            end
        end
    end

    // One conversion: start pulse, queue expectation, check latency, busy and done width.
    task automatic run_conv(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                            input logic [6:0] p0, input logic [10:0] ev, input logic ei,
                            input logic eo);
        int lat;
        int busy_cnt;
        exp_t e;
        e.value    = ev;
        e.invalid  = ei;
        e.overflow = eo;
        @(negedge clk);
        display3 = p3;
        display2 = p2;
        display1 = p1;
        display0 = p0;
        start    = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 12) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, 32'd5);
        check_eq("busy_cycles", busy_cnt, 32'd4);
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("done_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   guard;
        n_tests  = 0;
        n_fail   = 0;
        start    = 1'b0;
        display3 = PB;
        display2 = PB;
        display1 = PB;
        display0 = PB;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_value", {21'd0, value}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_invalid", {31'd0, invalid}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        run_conv(PB, PB, PB, P0, 11'd0, 1'b0, 1'b0);
        run_conv(P1, P2, P3, P4, 11'd1234, 1'b0, 1'b0);
        run_conv(P2, P0, P4, P7, 11'd2047, 1'b0, 1'b0);
        run_conv(P9, P9, P9, P9, 11'd2047, 1'b0, 1'b1);
        run_conv(PB, P5, PB, P7, 11'd507, 1'b1, 1'b0);
        run_conv(P1, P2, P3, PX, 11'd1230, 1'b1, 1'b0);
        run_conv(PB, PB, PB, PB, 11'd0, 1'b0, 1'b0);
        run_conv(P2, P0, P4, P8, 11'd2047, 1'b0, 1'b1);
        run_conv(P0, P0, P0, P9, 11'd9, 1'b0, 1'b0);
        run_conv(P5, PB, P0, P0, 11'd2047, 1'b1, 1'b1);

        // Inputs change and start repeats while busy: snapshot wins, no extra done.
        e.value = 11'd1234; e.invalid = 1'b0; e.overflow = 1'b0;
        @(negedge clk);
        display3 = P1; display2 = P2; display1 = P3; display0 = P4;
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        display3 = P9; display2 = P9; display1 = P9; display0 = P9;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("busy_ignore_drain", sb_q.size(), 32'd0);

        // Start held high: re-accepted in the done cycle.
        e.value = 11'd1234; e.invalid = 1'b0; e.overflow = 1'b0;
        display3 = P1; display2 = P2; display1 = P3; display0 = P4;
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        display3 = P2; display2 = P0; display1 = P4; display0 = P7;
        e.value = 11'd2047;
        sb_q.push_back(e);
        guard = 0;
        while (done !== 1'b1 && guard < 12) begin
            @(negedge clk);
            guard++;
        end
        check_eq("held_first_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_eq("held_rearm_busy", {31'd0, busy}, 32'd1);
        check_eq("held_rearm_done", {31'd0, done}, 32'd0);
        repeat (8) @(negedge clk);
        check_eq("held_drain", sb_q.size(), 32'd0);

        // Reset at E2 of a 1234 conversion: immediate clear, no done afterwards.
        display3 = P1; display2 = P2; display1 = P3; display0 = P4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_value", {21'd0, value}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("abort_no_done", sb_q.size(), 32'd0);
        run_conv(P1, P2, P3, P4, 11'd1234, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("final_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/four_digit_display_decoder.md
# four_digit_display_decoder

Sequential decoder that reads back four active-low 7-segment digit patterns, as driven onto the board's HEX displays, and reconstructs the 11-bit binary value they show. It is the reverse of the binary-to-display path. It sits next to the score/timer display logic as an on-chip self-check and scoreboard monitor, and benches can instantiate it to check display output without hand-decoding segment bits.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request conversion; sampled only in IDLE
- display3  in  7  most-significant digit pattern, active-low, bit0=a … bit6=g
- display2  in  7  hundreds digit pattern
- display1  in  7  tens digit pattern
- display0  in  7  units digit pattern
- value  out  11  decoded value, held until next done
- done  out  1  one-cycle pulse: value/invalid/overflow updated
- busy  out  1  high while a conversion is in progress
- invalid  out  1  last conversion saw an illegal or misplaced pattern
- overflow  out  1  last conversion exceeded 2047 and was saturated

## Operation
- Legal patterns (active-low, g..a):
  - 0=1000000
  - 1=1111001
  - 2=0100100
  - 3=0110000
  - 4=0011001
  - 5=0010010
  - 6=0000010
  - 7=1111000
  - 8=0000000
  - 9=0010000
  - blank=1111111
- Blank is legal only as a leading digit, i.e. before any non-blank digit in display3→display0 order. A blank counts as digit 0.
- A blank after a non-blank digit, or any other pattern, sets the conversion's invalid flag and counts as digit 0.
- All four blank decodes to 0 with invalid=0.
- FSM states:
  - IDLE: wait for start. On start=1, capture display3..0 into a snapshot register, clear acc (14 bits), invalid and seen-nonblank flags, set idx=3, go to CONV. Later input changes do not affect the conversion.
  - CONV: each cycle, acc ← acc*10 + digit(idx), computed as (acc<<3)+(acc<<1)+d in 14 bits (max 9999 fits). Update the flags, then decrement idx. After idx 0, go to IDLE and register the results.
- Result registration, on the same edge that processes idx 0:
  - value ← (final acc > 2047) ? 2047 : final acc[10:0]
  - overflow ← final acc > 2047
  - invalid ← sticky flag
  - done ← 1
- done is cleared on every other edge.
- busy = (state == CONV).
- start while busy is ignored and not queued.
- start during the done-pulse cycle is accepted, because the FSM is in IDLE.

## Timing
- Reset (async, immediate): state=IDLE, value=0, done=0, busy=0, invalid=0, overflow=0, acc=0, idx=3.
- Reset mid-conversion aborts it. No done pulse follows, and outputs take their reset values.
- Start sampled at edge E0. busy goes high after E0. CONV edges are E1..E4.
- After E4: busy=0, done=1 for exactly one cycle, results valid from the same cycle.
- Latency from the start edge to done high is 4 clocks. Back-to-back throughput is one conversion per 5 clocks: start held high is re-accepted in the done cycle.
- value, invalid and overflow change only on done edges or reset.

## Test plan
- Reset, then snapshot blank,blank,blank,0 (1111111,1111111,1111111,1000000) with start pulse → done after 4 clocks, value=0, invalid=0, overflow=0.
- Patterns 1,2,3,4 → value=1234 (10011010010), flags 0. Check busy is high for exactly 4 cycles and done lasts exactly 1 cycle.
- Patterns 2,0,4,7 → value=2047, overflow=0. Patterns 9,9,9,9 → value=2047, overflow=1.
- Patterns blank,5,blank,7 → invalid=1, value=507. Pattern 0101010 in display0 with 1,2,3 above → invalid=1, value=1230.
- Change display inputs and pulse start during busy → result matches the original snapshot, and the second start produces no extra done. Hold start high → a new conversion begins in the done cycle.
- Assert rst at E2 of a conversion of 1,2,3,4 → outputs go to 0 immediately, no done follows. A fresh start after reset release converts correctly.
